fp_div_core: RTL and testbench
==============================

FP_DIV_CORE -- requirements
Module: fp_div_core

Interface
REQ-001 Parameter LATENCY, default 27, fixed; the clock count from start acceptance to done; documentation only, never overridden.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a division of in1/in2; sampled only in IDLE.
REQ-005 in1  input  32  IEEE-754 single-precision dividend.
REQ-006 in2  input  32  IEEE-754 single-precision divisor.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse when temp_result is updated.
REQ-009 temp_result  output  32  raw quotient, fed to export_result for the special-case override.

Function
REQ-010 States SHALL be IDLE, DIV, NORM and DONE.
REQ-011 Transitions SHALL be: IDLE->DIV on start; DIV->NORM after 25 iterations; NORM->DONE; DONE->IDLE unconditionally.
REQ-012 On acceptance, the block SHALL latch in1/in2 and form:
- sign s = in1[31]^in2[31];
- Ma = {1,in1[22:0]} and Mb = {1,in2[22:0]};
- ea = in1[30:23] and eb = in2[30:23].
REQ-013 DIV SHALL perform restoring division of {Ma,24'b0} by Mb, one quotient bit per cycle, MSB first, for 25 cycles, giving q[24:0].
REQ-014 Exponent arithmetic SHALL use a 10-bit signed value e = ea - eb + 127.
REQ-015 NORM: if q[24]=1, mantissa = q[23:1] and e is unchanged; otherwise mantissa = q[22:0] and e = e - 1.
REQ-016 Rounding SHALL truncate (round toward zero); no sticky or guard bits.
REQ-017 Overflow: e >= 255 SHALL give temp_result = {s,8'hFF,23'h0}.
REQ-018 Underflow: e <= 0 SHALL give temp_result = {s,31'h0}; no denormal output.
REQ-019 Special inputs: if ea or eb is 0 or 255, temp_result SHALL be {s,31'h0}, with the same latency.
- The sign SHALL still be correct; export_result consumes temp_result[31].
REQ-020 The register temp_result SHALL be loaded on the NORM->DONE edge and hold until the next NORM->DONE edge.
REQ-021 done SHALL be high exactly during the DONE state, i.e. the 27th cycle after the start-sampling edge.
REQ-022 busy SHALL be high in DIV, NORM and DONE, and low in IDLE.
REQ-023 start SHALL be ignored while busy=1, including during the DONE cycle; in1/in2 changes after acceptance SHALL have no effect.
REQ-024 Back-to-back operations: start held high SHALL be accepted again in the IDLE cycle following DONE.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, with busy=0, done=0 and temp_result=32'h0, regardless of clk.
REQ-026 Reset mid-division SHALL discard the operation; no done pulse SHALL follow.
REQ-027 After rst deasserts, the first start seen in IDLE SHALL be accepted normally.

Verification
REQ-028 in1=0x40C00000, in2=0x40000000, start pulse -> done 27 cycles later, temp_result=0x40400000.
REQ-029 in1=0x3F800000, in2=0x40400000 -> temp_result=0x3EAAAAAA (truncated).
REQ-030 in1=0xBF800000, in2=0x40000000 -> temp_result=0xBF000000.
REQ-031 in1=0x7F000000, in2=0x00800000 -> temp_result=0x7F800000; with in1/in2 swapped -> 0x00000000.
REQ-032 in1=0x80000000, in2=0x40000000 -> temp_result=0x80000000; start pulses while busy -> no extra done.
REQ-033 Assert rst at cycle 10 of a division -> busy=0, done=0 and temp_result=0 immediately; no done afterwards; a new start then completes in 27 cycles.

Source files
------------

// File: rtl/fp_div_core_if.sv
// fp_div_core_if: request/response bundle for the single-precision divider.
//   start       : request a division of in1/in2 (master -> slave)
//   in1, in2    : IEEE-754 single-precision dividend / divisor (master -> slave)
//   busy        : division in progress (slave -> master)
//   done        : one-cycle pulse when temp_result is updated (slave -> master)
//   temp_result : raw quotient before special-case export (slave -> master)
interface fp_div_core_if;
    logic        start;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic        done;
    logic [31:0] temp_result;

    modport master (
        output start, in1, in2,
        input  busy, done, temp_result
    );

    modport slave (
        input  start, in1, in2,
        output busy, done, temp_result
    );
endinterface

// File: rtl/fp_div_core.sv
// fp_div_core: multi-cycle IEEE-754 single-precision divider, truncating,
// no denormal output. Restoring division produces one quotient bit per cycle.
//
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fp_div_core_if.slave (start, in1, in2, busy, done, temp_result)
//
// Timing: start accepted at an IDLE edge; 25 DIV cycles, one NORM cycle, then
// done is high for the DONE cycle, the 27th cycle counting the accepting one.
//
//   state | meaning
//   IDLE  | waiting for start
//   DIV   | one restoring-division quotient bit per cycle, 25 cycles
//   NORM  | normalise, exponent check, temp_result loaded on exit
//   DONE  | done pulse; start ignored
module fp_div_core #(
    parameter int LATENCY = 27
) (
    input  logic          clk,
    input  logic          rst,
    fp_div_core_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [24:0]        rem_q, rem_d;
    logic [24:0]        quo_q, quo_d;
    logic [23:0]        mb_q, mb_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic               special_q, special_d;
    logic [31:0]        temp_result_q, temp_result_d;

    logic               accept;
    logic [24:0]        rem_sub;
    logic               rem_ge;
    logic [24:0]        rem_next;
    logic signed [9:0]  exp_norm;
    logic [22:0]        mant_norm;
    logic [31:0]        result_norm;
    logic [7:0]         ea, eb;

    assign accept = (state_q == IDLE) && bus.start;
    assign ea     = bus.in1[30:23];
    assign eb     = bus.in2[30:23];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = DIV;
            DIV:     if (cnt_q == 5'd0) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
    end

    assign bus.temp_result = temp_result_q;

    // Restoring-division step. The remainder stays below Mb after a
    // subtraction, so the left shift never loses a significant bit.
    always_comb begin
        rem_sub  = rem_q - {1'b0, mb_q};
        rem_ge   = (rem_q >= {1'b0, mb_q});
        rem_next = rem_ge ? rem_sub : rem_q;
    end

    // Normalisation and range check of the finished quotient
    always_comb begin
        exp_norm    = quo_q[24] ? exp_q : (exp_q - 10'sd1);
        mant_norm   = quo_q[24] ? quo_q[23:1] : quo_q[22:0];
        result_norm = {sign_q, exp_norm[7:0], mant_norm};
        if (special_q) begin
            result_norm = {sign_q, 31'h0};
        end else if (exp_norm >= 10'sd255) begin
            result_norm = {sign_q, 8'hFF, 23'h0};
        end else if (exp_norm <= 10'sd0) begin
            result_norm = {sign_q, 31'h0};
        end
    end

    // Datapath next-state
    always_comb begin
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        mb_d          = mb_q;
        exp_d         = exp_q;
        sign_d        = sign_q;
        special_d     = special_q;
        temp_result_d = temp_result_q;
        if (accept) begin
            sign_d    = bus.in1[31] ^ bus.in2[31];
            rem_d     = {1'b0, 1'b1, bus.in1[22:0]};
            mb_d      = {1'b1, bus.in2[22:0]};
            exp_d     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
            special_d = (ea == 8'h00) || (ea == 8'hFF) || (eb == 8'h00) || (eb == 8'hFF);
            quo_d     = 25'h0;
            cnt_d     = 5'd24;
        end else if (state_q == DIV) begin
            quo_d = {quo_q[23:0], rem_ge};
            rem_d = rem_next << 1;
            cnt_d = cnt_q - 5'd1;
        end else if (state_q == NORM) begin
            temp_result_d = result_norm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= 5'd0;
            rem_q         <= 25'h0;
            quo_q         <= 25'h0;
            mb_q          <= 24'h0;
            exp_q         <= 10'sd0;
            sign_q        <= 1'b0;
            special_q     <= 1'b0;
            temp_result_q <= 32'h0;
        end else begin
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            mb_q          <= mb_d;
            exp_q         <= exp_d;
            sign_q        <= sign_d;
            special_q     <= special_d;
            temp_result_q <= temp_result_d;
        end
    end

endmodule

// File: tb/tb_fp_div_core.sv
// tb_fp_div_core: directed vectors with hand-computed quotients for fp_div_core.
module tb_fp_div_core;
    localparam int EXP_LAT = 27;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fp_div_core_if bus ();

    fp_div_core #(.LATENCY(27)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one operation, wait for done (bounded), check latency, busy and result.
    // With poke set, start and in1 are disturbed while busy, including in DONE.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit poke);
        int n;
        bit got;
        @(negedge clk);
        bus.in1   = a;
        bus.in2   = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) got = 1'b1;
            if (poke && n == 5) begin
                bus.start = 1'b1;
                bus.in1   = 32'h12345678;
                bus.in2   = 32'h3F800000;
            end
            if (poke && n == 7) bus.start = 1'b0;
        end
        check({tag, "_done_seen"}, {31'h0, got}, 32'h1);
        check({tag, "_latency"}, n + 1, EXP_LAT);
        check({tag, "_busy_in_done"}, {31'h0, bus.busy}, 32'h1);
        check({tag, "_result"}, bus.temp_result, exp);
        if (poke) bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_idle_busy"}, {31'h0, bus.busy}, 32'h0);
        check({tag, "_idle_done"}, {31'h0, bus.done}, 32'h0);
        if (poke) begin
            @(posedge clk);
            #1;
            check({tag, "_no_extra_start"}, {31'h0, bus.busy}, 32'h0);
            check({tag, "_result_hold"}, bus.temp_result, exp);
        end
    endtask

    initial begin
        int n;
        bit got;
        n_checks  = 0;
        n_fail    = 0;
        bus.start = 1'b0;
        bus.in1   = 32'h0;
        bus.in2   = 32'h0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'h0, bus.busy}, 32'h0);
        check("reset_done", {31'h0, bus.done}, 32'h0);
        check("reset_result", bus.temp_result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_div("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        run_div("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);
        run_div("neg_half",    32'hBF800000, 32'h40000000, 32'hBF000000, 1'b0);
        run_div("overflow",    32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0);
        run_div("underflow",   32'h00800000, 32'h7F000000, 32'h00000000, 1'b0);
        run_div("neg_zero_in", 32'h80000000, 32'h40000000, 32'h80000000, 1'b1);
        run_div("inf_divisor", 32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0);

        // Back-to-back: start held high across DONE
        @(negedge clk);
        bus.in1   = 32'h40C00000;
        bus.in2   = 32'h40000000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) got = 1'b1;
        end
        check("b2b_first_latency", n + 1, EXP_LAT);
        check("b2b_first_result", bus.temp_result, 32'h40400000);
        bus.in1 = 32'hBF800000;
        bus.in2 = 32'h40000000;
        @(posedge clk);
        #1;
        check("b2b_idle_gap", {31'h0, bus.busy}, 32'h0);
        @(posedge clk);
        #1;
        check("b2b_reaccept", {31'h0, bus.busy}, 32'h1);
        bus.start = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) got = 1'b1;
        end
        check("b2b_second_latency", n + 1, EXP_LAT);
        check("b2b_second_result", bus.temp_result, 32'hBF000000);
        @(posedge clk);
        #1;

        // Reset in the middle of a division
        @(negedge clk);
        bus.in1   = 32'h3F800000;
        bus.in2   = 32'h40400000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("mid_busy_before_rst", {31'h0, bus.busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_async_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_async_done", {31'h0, bus.done}, 32'h0);
        check("rst_async_result", bus.temp_result, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) got = 1'b1;
        end
        check("rst_no_done_after", {31'h0, got}, 32'h0);
        run_div("after_reset", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
